sample_capture_ram: RTL
=======================

Name: sample_capture_ram

Overview:
- Write-side counterpart to the sine lookup ROM.
- Captures a stream of DATA_WIDTH samples (e.g. ADC or generated waveform) into an on-chip RAM under a small arm/capture/done state machine.
- Exposes an independent synchronous read port with the same 1-cycle registered latency as the ROM, so downstream display/playback logic can read it the same way.
- Sits between the sample source and the read/playback path of the signal generator.

Parameters:
- ADDRESS_WIDTH, 8, address bits; depth = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 8, sample width in bits.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- arm  input  1  single-cycle pulse; starts a capture (restart/stop rules below).
- wr_en  input  1  sample valid; din is written when high in CAPTURE.
- din  input  DATA_WIDTH  sample to store.
- rd_addr  input  ADDRESS_WIDTH  read address.
- dout  output  DATA_WIDTH  registered read data.
- wr_ptr  output  ADDRESS_WIDTH  next write address.
- busy  output  1  high in CAPTURE.
- done  output  1  high in DONE.

Behaviour:
- Reset, sampled on posedge clk with rst=1:
  - State goes to IDLE.
  - wr_ptr=0, dout=0, busy=0, done=0.
  - RAM contents are not cleared.
  - rst has priority over all other inputs.
- States:
  - IDLE: wr_en ignored. arm=1 → CAPTURE with wr_ptr=0.
  - CAPTURE:
    - wr_en=1 writes mem[wr_ptr] <= din and increments wr_ptr.
    - A write at wr_ptr = 2**ADDRESS_WIDTH-1 → DONE, with wr_ptr wrapping to 0.
    - wr_en=0 holds state and pointer.
  - DONE: holds; done=1; wr_en ignored. arm=1 → CAPTURE with wr_ptr=0.
- arm while in CAPTURE (macro undefined): restart. wr_ptr=0 next cycle; any wr_en in the same cycle is dropped, not written.
- busy and done are registered state decodes, valid the cycle after each transition. They are never high together.
- Read port:
  - dout <= mem[rd_addr] every cycle, regardless of state.
  - Latency is 1 cycle.
- Read/write collision: same address in the same cycle returns the old (pre-write) data; the new data is visible from the next cycle.
- wr_ptr arithmetic is modulo 2**ADDRESS_WIDTH; no overflow flag.
- A full capture writes exactly 2**ADDRESS_WIDTH samples, at addresses 0..depth-1 in order.
- Memory is inferable as simple dual-port block RAM: one write port, one registered read port.

Optional Feature:
- Macro: CAPTURE_LOOP_EN.
- Defined:
  - CAPTURE wraps wr_ptr from depth-1 to 0 and keeps writing (circular buffer); it never enters DONE by filling.
  - arm during CAPTURE → DONE (stop) instead of restart; the wr_en sample in that cycle is dropped.
  - On stop, wr_ptr holds the oldest sample address.
- Undefined: single-shot behaviour as above.

Test Plan:
- Reset then readout: rst 1 cycle; rd_addr=0..3 → dout=0 after reset, then old RAM contents; busy=0, done=0, wr_ptr=0.
- Single-shot fill: arm, then 256 cycles of wr_en=1 with din=addr^8'hA5 → busy=1 throughout; done=1 the cycle after the 256th write; wr_ptr=0; reading addr 0x10 gives 0xB5 one cycle later.
- Gapped writes: wr_en toggling 1,0,1,0 with din=0x11,0x22 → mem[0]=0x11, mem[1]=0x22, wr_ptr=2, and the wr_en=0 cycles change nothing.
- Restart mid-capture: 5 writes, then arm with wr_en=1, din=0xFF → wr_ptr=0, 0xFF not written, mem[0] keeps its earlier value until rewritten.
- Collision: CAPTURE at wr_ptr=7 with old mem[7]=0x33; write 0x44 with rd_addr=7 → dout=0x33 next cycle, 0x44 the cycle after.
- CAPTURE_LOOP_EN: 300 writes with din=count[7:0], then arm → done=1; wr_ptr=300 mod 256=44; mem[43]=0x2B (value 299 mod 256); mem[44]=0x2C (value 44).

Source files
------------

// File: rtl/sample_capture_ram_if.sv
// Sample capture RAM bus: arm/write stream in, read port and status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the source owns wr_en, the RAM never stalls it.
interface sample_capture_ram_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) ();
    logic                     arm;
    logic                     wr_en;
    logic [DATA_WIDTH-1:0]    din;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]    dout;
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic                     busy;
    logic                     done;

    // Sample source / reader side
    modport master (
        output arm, wr_en, din, rd_addr,
        input  dout, wr_ptr, busy, done
    );

    // Capture RAM side
    modport slave (
        input  arm, wr_en, din, rd_addr,
        output dout, wr_ptr, busy, done
    );
endinterface

// File: rtl/sample_capture_ram.sv
// Captures a sample stream into a simple dual-port RAM under IDLE/CAPTURE/DONE control.
// Latency: registered read, dout valid 1 cycle after rd_addr; busy/done 1 cycle after transition.
// Backpressure: none; wr_en is accepted every cycle in CAPTURE. Macro CAPTURE_LOOP_EN selects circular capture.
module sample_capture_ram #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    sample_capture_ram_if.slave bus
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [DATA_WIDTH-1:0]    dout_q, dout_d;
    logic                     mem_we;

    // Storage is left unreset so it maps onto block RAM.
    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    // Next-state, write pointer and write enable; arm always wins over a same-cycle wr_en.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.arm) begin
                    state_d  = CAPTURE;
                    wr_ptr_d = '0;
                end
            end
            CAPTURE: begin
                if (bus.arm) begin
`ifdef CAPTURE_LOOP_EN
                    // Stop: pointer stays on the oldest sample of the circular buffer.
                    state_d  = DONE;
`else
                    // Restart from the top of the buffer.
                    wr_ptr_d = '0;
`endif
                end else if (bus.wr_en) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(1);
`ifndef CAPTURE_LOOP_EN
                    if (wr_ptr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            DONE: begin
                if (bus.arm) begin
                    state_d  = CAPTURE;
                    wr_ptr_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_ptr_d = '0;
            end
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
        busy_d = (state_d == CAPTURE);
        done_d = (state_d == DONE);
        dout_d = mem[bus.rd_addr];
    end

    // Control and read-data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dout_q   <= dout_d;
        end
    end

    // Single RAM write port; a same-address read this cycle still sees the old word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.wr_ptr = wr_ptr_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
